// File: rtl/dma_debug_s2mm_writer.sv
// dma_debug_s2mm_writer
//   Debug bring-up path for the AXI write channel. A software start issues
//   exactly one AXI4 INCR write burst whose beats are taken straight from an
//   AXI-Stream slave. Busy/done/error status is reported to the register file.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   cfg_start/len/size/addr      start pulse and burst parameters (sampled on start)
//   sts_busy, sts_done, sts_err  status: busy level, one-cycle done, sticky error
//   m_axi_aw*                    write address channel (master)
//   m_axi_w*                     write data channel (master)
//   m_axi_b*                     write response channel (master)
//   s_axis_*                     stream data source (slave)
module dma_debug_s2mm_writer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [7:0]            cfg_len,
  input  logic [2:0]            cfg_size,
  input  logic [ADDR_W-1:0]     cfg_addr,
  output logic                  sts_busy,
  output logic                  sts_done,
  output logic                  sts_err,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready
);

  localparam int LANES  = DATA_W / 8;
  localparam int LW     = $clog2(LANES);
  localparam int LANE_W = (LW > 0) ? LW : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state;
  logic [7:0]        beat_cnt;
  logic              err_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LANE_W-1:0] lane_q;

  logic in_aw, in_w, in_b;
  logic start_ok, size_bad, w_hs, last_beat;

  // First byte lane of the burst: the start address aligned down to the beat size.
  function automatic logic [LANE_W-1:0] lane_init(input logic [LANE_W-1:0] a,
                                                  input logic [2:0] sz);
    logic [LANE_W-1:0] mask;
    mask = LANE_W'((32'd1 << sz) - 32'd1);
    if (LW == 0) return '0;
    return a & ~mask;
  endfunction

  // Narrow transfers rotate through the byte lanes; wrap is implicit in LANE_W bits.
  function automatic logic [LANE_W-1:0] lane_next(input logic [LANE_W-1:0] l,
                                                  input logic [2:0] sz);
    if (LW == 0) return '0;
    return l + LANE_W'(32'd1 << sz);
  endfunction

  // Aligned lanes never overrun the bus, so a 32-bit intermediate covers up to 128-bit data.
  function automatic logic [LANES-1:0] strb_calc(input logic [LANE_W-1:0] l,
                                                 input logic [2:0] sz);
    logic [31:0] m;
    m = (32'd1 << (32'd1 << sz)) - 32'd1;
    m = m << l;
    return m[LANES-1:0];
  endfunction

  assign in_aw     = (state == S_AW);
  assign in_w      = (state == S_W);
  assign in_b      = (state == S_B);
  assign start_ok  = (state == S_IDLE) && cfg_start;
  assign size_bad  = (int'(cfg_size) > LW);
  assign w_hs      = in_w && s_axis_tvalid && m_axi_wready;
  assign last_beat = (beat_cnt == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      beat_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cfg_start) begin
          beat_cnt <= 8'd0;
          err_q    <= size_bad;
          state    <= size_bad ? S_DONE : S_AW;
        end
        S_AW:   if (m_axi_awready) state <= S_W;
        S_W:    if (w_hs) begin
          beat_cnt <= beat_cnt + 8'd1;
          if (last_beat) state <= S_B;
        end
        S_B:    if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) err_q <= 1'b1;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Burst parameters: loaded on an accepted start, never cleared (outputs are gated by state).
  always_ff @(posedge clk) begin
    if (start_ok) begin
      len_q  <= cfg_len;
      size_q <= cfg_size;
      addr_q <= cfg_addr;
      lane_q <= lane_init(cfg_addr[LANE_W-1:0], cfg_size);
    end else if (w_hs) begin
      lane_q <= lane_next(lane_q, size_q);
    end
  end

  assign m_axi_awvalid = in_aw;
  assign m_axi_awaddr  = in_aw ? addr_q : '0;
  assign m_axi_awlen   = in_aw ? len_q : 8'd0;
  assign m_axi_awsize  = in_aw ? size_q : 3'd0;
  assign m_axi_awburst = in_aw ? 2'b01 : 2'b00;

  assign m_axi_wvalid  = in_w && s_axis_tvalid;
  assign s_axis_tready = in_w && m_axi_wready;
  assign m_axi_wdata   = in_w ? s_axis_tdata : '0;
  assign m_axi_wstrb   = in_w ? strb_calc(lane_q, size_q) : '0;
  assign m_axi_wlast   = in_w && last_beat;

  assign m_axi_bready  = in_b;

  assign sts_busy = (state != S_IDLE);
  assign sts_done = (state == S_DONE);
  assign sts_err  = err_q;

endmodule

// File: tb/tb_dma_debug_s2mm_writer.sv
module tb_dma_debug_s2mm_writer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_start = 1'b0;
  logic [7:0]        cfg_len = '0;
  logic [2:0]        cfg_size = '0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic              sts_busy, sts_done, sts_err;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [7:0]        m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic [1:0]        m_axi_awburst;
  logic              m_axi_awvalid;
  logic              m_axi_awready = 1'b1;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wlast, m_axi_wvalid;
  logic              m_axi_wready = 1'b1;
  logic [1:0]        m_axi_bresp = 2'b00;
  logic              m_axi_bvalid = 1'b1;
  logic              m_axi_bready;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;

  dma_debug_s2mm_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_size(cfg_size), .cfg_addr(cfg_addr),
    .sts_busy(sts_busy), .sts_done(sts_done), .sts_err(sts_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } aw_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_exp_t;

  aw_exp_t awq[$];
  w_exp_t  wq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_awvalid"}, m_axi_awvalid, 0);
    chk({tag, "_awaddr"},  m_axi_awaddr, 0);
    chk({tag, "_wvalid"},  m_axi_wvalid, 0);
    chk({tag, "_wdata"},   m_axi_wdata, 0);
    chk({tag, "_wstrb"},   m_axi_wstrb, 0);
    chk({tag, "_wlast"},   m_axi_wlast, 0);
    chk({tag, "_bready"},  m_axi_bready, 0);
    chk({tag, "_tready"},  s_axis_tready, 0);
    chk({tag, "_busy"},    sts_busy, 0);
    chk({tag, "_done"},    sts_done, 0);
    chk({tag, "_err"},     sts_err, 0);
  endtask

  // One complete burst: push expectations, pulse start, then service the bus
  // until done (bounded), checking every handshake against the scoreboard.
  task automatic run_burst(input logic [7:0] len, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] dbase,
                           input bit stall, input logic [1:0] bresp,
                           input bit restart_mid, input int exp_done_cyc);
    bit      bad;
    bit      exp_err;
    bit      done;
    int      nb, lane0, lane, c, idx;
    aw_exp_t a;
    w_exp_t  w;
    logic [31:0] m;
    bad     = (size > 3'd2);
    exp_err = bad || (bresp != 2'b00);
    if (!bad) begin
      awq.push_back('{addr: addr, len: len, size: size});
      nb    = 1 << size;
      lane0 = (addr % 4) & ~(nb - 1);
      for (int i = 0; i <= len; i++) begin
        lane = (lane0 + i * nb) % 4;
        m    = ((32'd1 << nb) - 32'd1) << lane;
        wq.push_back('{data: dbase + i, strb: m[3:0], last: (i == len)});
      end
    end
    @(negedge clk);
    cfg_start = 1'b1; cfg_len = len; cfg_size = size; cfg_addr = addr;
    m_axi_bresp = bresp;
    c = 0; idx = 0; done = 1'b0;
    while (!done && c < 3000) begin
      @(negedge clk);
      c++;
      // values outside the start cycle must have no effect
      cfg_len  = ~len;
      cfg_size = 3'd0;
      cfg_addr = addr ^ 32'h0000_0F0C;
      cfg_start = restart_mid && (c == 3);
      m_axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axis_tvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_bvalid  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axis_tdata  = dbase + idx;
      #1;
      if (c == 1) begin
        chk("err_at_start", sts_err, bad);
        chk("awvalid_first", m_axi_awvalid, !bad);
      end
      chk("busy_during", sts_busy, 1);
      if (m_axi_awvalid && m_axi_awready) begin
        if (awq.size() == 0) chk("aw_extra", 1, 0);
        else begin
          a = awq.pop_front();
          chk("awaddr", m_axi_awaddr, a.addr);
          chk("awlen", m_axi_awlen, a.len);
          chk("awsize", m_axi_awsize, a.size);
          chk("awburst", m_axi_awburst, 2'b01);
        end
      end
      if (m_axi_wvalid && m_axi_wready) begin
        chk("tready_hs", s_axis_tready, 1);
        if (wq.size() == 0) chk("w_extra", 1, 0);
        else begin
          w = wq.pop_front();
          chk("wdata", m_axi_wdata, w.data);
          chk("wstrb", m_axi_wstrb, w.strb);
          chk("wlast", m_axi_wlast, w.last);
        end
        idx++;
      end
      if (sts_done) begin
        done = 1'b1;
        chk("err_final", sts_err, exp_err);
        if (exp_done_cyc > 0) chk("done_cycle", c, exp_done_cyc);
      end
    end
    if (!done) chk("done_timeout", 1, 0);
    cfg_start = 1'b0;
    @(negedge clk);
    #1;
    chk("busy_after", sts_busy, 0);
    chk("done_after", sts_done, 0);
    chk("err_hold", sts_err, exp_err);
    chk("wq_drained", wq.size(), 0);
    chk("awq_drained", awq.size(), 0);
    wq.delete();
    awq.delete();
  endtask

  initial begin
    #2;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_outputs_zero("idle");

    run_burst(8'd3,   3'd2, 32'h0000_1000, 32'h0000_00A0, 1'b0, 2'b00, 1'b0, 7);
    run_burst(8'd5,   3'd0, 32'h0000_2002, 32'h1234_0000, 1'b0, 2'b00, 1'b0, 9);
    run_burst(8'd255, 3'd2, 32'h0000_8000, 32'h5500_0000, 1'b1, 2'b00, 1'b0, 0);
    run_burst(8'd2,   3'd1, 32'h0000_3001, 32'h0BAD_0000, 1'b0, 2'b10, 1'b0, 6);
    run_burst(8'd4,   3'd3, 32'h0000_5000, 32'h0000_0000, 1'b0, 2'b00, 1'b0, 1);
    run_burst(8'd5,   3'd2, 32'h0000_4000, 32'h7700_0000, 1'b0, 2'b00, 1'b1, 9);

    // Reset in the middle of the data phase must drop everything at once.
    @(negedge clk);
    cfg_start = 1'b1; cfg_len = 8'd7; cfg_size = 3'd2; cfg_addr = 32'h0000_6000;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; s_axis_tvalid = 1'b1; m_axi_bvalid = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_w_wvalid", m_axi_wvalid, 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_outputs_zero("after_midreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dma_debug_s2mm_writer.md
Name: dma_debug_s2mm_writer

Overview:
Hardware consumer of the DMA CSR DEBUG_CR.S2MM_* fields, DEBUG_S2MM_ADDR and DEBUG_SR.S2MM_BUSY.
- On a software start, it issues exactly one AXI4 INCR write burst to memory.
- Burst data comes from an AXI-Stream slave port.
- It reports busy, done and error status back to the register file.
- It sits beside the DMA core and serves as a bring-up path for exercising the AXI write channel independently of the main S2MM engine.

Parameters:
- DATA_W, 32, AXI/AXIS data width in bits; power of two, 8..128.
- ADDR_W, 32, AXI address width; matches DEBUG_S2MM_ADDR.ADDR.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle pulse from DEBUG_CR.S2MM_START write
- cfg_len  in  8  AXI awlen (beats-1), DEBUG_CR.S2MM_LEN
- cfg_size  in  3  AXI awsize, DEBUG_CR.S2MM_SIZE
- cfg_addr  in  ADDR_W  start address, DEBUG_S2MM_ADDR
- sts_busy  out  1  drives DEBUG_SR.S2MM_BUSY
- sts_done  out  1  one-cycle pulse at end of transfer
- sts_err  out  1  sticky error: bad size or non-OKAY bresp
- m_axi_awaddr/awlen/awsize/awburst  out  ADDR_W/8/3/2  write address
- m_axi_awvalid  out  1 / m_axi_awready  in  1
- m_axi_wdata  out  DATA_W / m_axi_wstrb  out  DATA_W/8 / m_axi_wlast  out  1
- m_axi_wvalid  out  1 / m_axi_wready  in  1
- m_axi_bresp  in  2 / m_axi_bvalid  in  1 / m_axi_bready  out  1
- s_axis_tdata  in  DATA_W / s_axis_tvalid  in  1 / s_axis_tready  out  1

Behaviour:
Reset values:
- All outputs 0; FSM in IDLE.
- Reset asserted mid-burst aborts immediately with no completion. AXI protocol recovery is the system reset's concern.

FSM states: IDLE, AW, W, B, DONE.

IDLE:
- On cfg_start, capture len, size and addr into internal registers.
- Clear sts_err.
- If size > log2(DATA_W/8): set sts_err, go to DONE with no bus activity.
- Otherwise go to AW.
- cfg_* inputs are ignored outside the start cycle.
- cfg_start in any state other than IDLE is ignored.

AW:
- awvalid=1; awaddr=captured addr; awlen=len; awsize=size; awburst=2'b01 (INCR).
- awvalid and payload are held stable until awready.
- On handshake, go to W. AW completes before the first W beat; no overlap.

W:
- wvalid=s_axis_tvalid; s_axis_tready=m_axi_wready; wdata=s_axis_tdata. Pass-through, zero added latency.
- An 8-bit beat counter starts at 0 and increments on each W handshake.
- wlast=1 when counter==len.
- On the handshake with wlast, go to B.
- Stream data outside W state is not accepted (tready=0).

Strobe rules:
- lane = addr[log2(DATA_W/8)-1:0] aligned down to 2^size; updated each beat.
- wstrb = ((1<<2^size)-1) << lane.
- After each beat, lane advances by 2^size modulo DATA_W/8 (narrow-transfer lane rotation).
- If size equals full width, wstrb is all ones on every beat.
- Unaligned start addresses: beat 0 uses the aligned-down lane. No partial first strobe.

Other rules:
- 4 KB boundary crossing is not checked; the burst is issued as programmed.

B:
- bready=1.
- On bvalid: if bresp!=2'b00, set sts_err. Go to DONE.

DONE:
- sts_done=1 for exactly one cycle, then IDLE.

sts_busy:
- 1 in AW, W, B and DONE; 0 in IDLE.
- Rises the cycle after cfg_start and falls the cycle after sts_done.

sts_err:
- Holds until the next accepted cfg_start.

Latency:
- awvalid rises 1 cycle after cfg_start.
- With awready, wready, tvalid and bvalid all tied high, a len=N burst completes with done at cycle N+4 after start.

Test Plan:
- DATA_W=32, start with len=3, size=2, addr=0x1000, all ready/valid high, stream 0xA0..0xA3 -> one AW (awlen=3, awsize=2, awburst=1); four W beats with wstrb=4'hF; wlast only on beat 3 (data 0xA3); done at cycle 7; err=0.
- size=0, len=5, addr=0x2002 -> wstrb sequence 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8.
- Random wready and tvalid stalls, len=255 -> exactly 256 beats; wlast on beat 255 only; data order preserved; no beat dropped or duplicated.
- bresp=2'b10 (SLVERR) -> sts_err=1 after B; done pulses; err clears on next start.
- size=3 with DATA_W=32 -> no awvalid; err=1; done pulses 1 cycle after start; busy high for exactly 1 cycle.
- cfg_start pulsed again during W, with altered cfg values -> ignored; burst finishes with the original parameters. Then assert rst_n=0 mid-W -> all outputs 0 immediately.
